soqpsk_lut_sequencer: RTL

- Sequences the SOQPSK waveform lookup ROM (512 x 14, registered address and output, 2-clock read latency).
- Accepts the transmit bit stream over a valid/ready handshake and keeps a 3-bit symbol history.
- Issues one ROM address per sample strobe and realigns the ROM data into a valid-qualified sample stream.
- Sits between the framer/bit source and the DAC/upconversion path.

---
 rtl/soqpsk_pkg.sv | 11 +
 rtl/soqpsk_prbs9.sv | 14 +
 rtl/soqpsk_lut_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/soqpsk_pkg.sv
// soqpsk_pkg: shared constants, FSM state type and PRBS-9 seed/taps for the SOQPSK LUT sequencer
package soqpsk_pkg;
  localparam int SPS_LOG2 = 6;
  localparam int HIST_W = 3;
  localparam int ROM_LAT = 2;
  localparam int SAMP_W = 14;
  localparam int ROM_AW = HIST_W + SPS_LOG2;
  localparam logic [8:0] PRBS_SEED = 9'h1FF;
  localparam logic [8:0] PRBS_TAPS = 9'h110;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/soqpsk_prbs9.sv
// soqpsk_prbs9: PRBS-9 (x^9+x^5+1) bit source that advances once per accepted bit
module soqpsk_prbs9
  import soqpsk_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic advance,
  output logic bit_out
);
  logic [8:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = advance ? {lfsr_q[7:0], ^(lfsr_q & PRBS_TAPS)} : lfsr_q;
  always_ff @(posedge clock) lfsr_q <= reset ? PRBS_SEED : lfsr_d;
  assign bit_out = lfsr_q[8];
endmodule

// File: rtl/soqpsk_lut_sequencer.sv
// soqpsk_lut_sequencer: SOQPSK waveform ROM sequencer; SOQPSK_TEST_PATTERN_EN adds a test_mode PRBS-9 bit source
module soqpsk_lut_sequencer
  import soqpsk_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              bit_valid,
`ifdef SOQPSK_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              bit_ready,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [SAMP_W-1:0] rom_q,
  output logic [SAMP_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              underrun,
  input  logic              underrun_clr
);
  state_t state_q, state_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [SPS_LOG2-1:0] idx_q, idx_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [SAMP_W-1:0] sample_q, sample_d;
  logic [ROM_LAT:0] vpipe_q, vpipe_d;
  logic fill_q, fill_d, underrun_q, underrun_d, sample_valid_q, sample_valid_d;
  logic tm, src_bit, src_valid, ready_int, set_ur;
`ifdef SOQPSK_TEST_PATTERN_EN
  logic prbs_bit;
  soqpsk_prbs9 u_prbs (.clock(clock), .reset(reset), .advance(tm & ready_int), .bit_out(prbs_bit));
  assign tm = test_mode;
  assign src_bit = tm ? prbs_bit : bit_in;
  assign src_valid = tm | bit_valid;
`else
  assign tm = 1'b0;
  assign src_bit = bit_in;
  assign src_valid = bit_valid;
`endif
  always_comb begin
    state_d = state_q;
    hist_d = hist_q;
    idx_d = idx_q;
    addr_d = addr_q;
    fill_d = fill_q;
    ready_int = 1'b0;
    set_ur = 1'b0;
    vpipe_d = {vpipe_q[ROM_LAT-1:0], 1'b0};
    sample_valid_d = vpipe_q[ROM_LAT];
    sample_d = vpipe_q[ROM_LAT] ? rom_q : sample_q;
    case (state_q)
      IDLE: begin
        ready_int = enable;
        if (enable && src_valid) begin
          hist_d = {hist_q[HIST_W-2:0], src_bit};
          idx_d = '0;
          state_d = RUN;
        end
      end
      RUN: if (sample_en) begin
        addr_d = {hist_q, idx_q};
        vpipe_d[0] = 1'b1;
        idx_d = idx_q + 1'b1;
        // symbol boundary: take the next bit, or repeat the fill pattern on underrun
        if (idx_q == '1) begin
          ready_int = enable;
          if (!enable) state_d = DRAIN;
          else if (src_valid) hist_d = {hist_q[HIST_W-2:0], src_bit};
          else begin
            hist_d = {hist_q[HIST_W-2:0], fill_q};
            fill_d = ~fill_q;
            set_ur = ~tm;
          end
        end
      end
      DRAIN: if (vpipe_q[ROM_LAT-1:0] == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    underrun_d = set_ur | (underrun_q & ~underrun_clr);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hist_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
      sample_q <= '0;
      vpipe_q <= '0;
      fill_q <= 1'b0;
      underrun_q <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      sample_q <= sample_d;
      vpipe_q <= vpipe_d;
      fill_q <= fill_d;
      underrun_q <= underrun_d;
      sample_valid_q <= sample_valid_d;
    end
  end
  assign bit_ready = ready_int & ~tm;
  assign rom_address = addr_q;
  assign sample_out = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy = state_q != IDLE;
  assign underrun = underrun_q;
endmodule
